// File: rtl/tl_bus_pkg.sv
// Shared types and TileLink-UL constants for the A-channel bus arbiter.
// Optional round-robin arbitration is enabled with TL_BUS_ARB_RR_EN.
package tl_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  localparam logic [2:0] TL_A_GET         = 3'h4;
  localparam logic [2:0] TL_A_PUTFULL     = 3'h0;
  localparam logic [2:0] TL_A_PUTPARTIAL  = 3'h1;
  localparam logic [2:0] TL_D_ACCESSACK   = 3'h0;
  localparam logic [2:0] TL_D_ACCESSACKD  = 3'h1;
  localparam logic [3:0] TL_SIZE_DEFAULT  = 4'h4;

endpackage

// File: rtl/tl_rr_pick.sv
// Rotated find-first-set: first set request at or after i_start, wrapping.
// Produces both one-hot and binary forms of the winner.
module tl_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx
);

  int w_j;

  // Walk from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = (int'(i_start) + k) % N;
      if (i_req[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = W'(w_j);
      end
    end
  end

endmodule

// File: rtl/tl_bus_arbiter.sv
// Grant controller for the 2-master TileLink-UL A-channel mux; one
// outstanding transaction at a time. Round-robin when TL_BUS_ARB_RR_EN.
module tl_bus_arbiter
  import tl_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int SRC_W       = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] io_req_valid,
  input  logic                   io_a_fire,
  input  logic                   io_d_fire,
  input  logic [SRC_W-1:0]       io_d_source,
  output logic [NUM_MASTERS-1:0] io_choseOH,
  output logic [SRC_W-1:0]       io_grant_idx,
  output logic                   io_busy
);

  state_e                   r_state;
  state_e                   w_next;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [SRC_W-1:0]         r_idx;
  logic [NUM_MASTERS-1:0]   w_pick_oh;
  logic [SRC_W-1:0]         w_pick_idx;
  logic [SRC_W-1:0]         w_start;
  logic                     w_any;
  logic                     w_d_match;

  assign w_any     = |io_req_valid;
  assign w_d_match = io_d_fire && (io_d_source == r_idx);

`ifdef TL_BUS_ARB_RR_EN
  logic [SRC_W-1:0] r_rr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == WAIT_D && w_d_match) begin
      r_rr_ptr <= SRC_W'((int'(r_idx) + 1) % NUM_MASTERS);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  tl_rr_pick #(
    .N (NUM_MASTERS),
    .W (SRC_W)
  ) u_pick (
    .i_req    (io_req_valid),
    .i_start  (w_start),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any)     w_next = GRANT;
      GRANT:   if (io_a_fire) w_next = WAIT_D;
      WAIT_D:  if (w_d_match) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick_oh;
        r_idx   <= w_pick_idx;
      end
    end
  end

  // Select only in GRANT; zero in WAIT_D gates mux ready.
  assign io_choseOH   = (r_state == GRANT) ? r_grant : '0;
  assign io_grant_idx = r_idx;
  assign io_busy      = (r_state != IDLE);

  always_ff @(posedge clock) begin
    assert ($onehot0(io_choseOH));
  end

endmodule

// File: doc/tl_bus_arbiter.md
Name: tl_bus_arbiter

Overview:
- Grant controller for the 2-master TileLink-UL A-channel mux; drives that mux's one-hot select (io_choseOH_*).
- Picks one requesting master and holds the grant until that master's A beat fires.
- Then blocks all masters until the matching D-channel response fires, so at most one transaction is outstanding on the shared bus.
- Sits between master request valids and the mux select inputs; observes the A handshake and D response at the mux output.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; one-hot grant width.
- SRC_W, 1, width of the D-channel source field; must satisfy 2^SRC_W >= NUM_MASTERS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_req_valid  in  NUM_MASTERS  per-master A-channel valid (bit i = master i).
- io_a_fire  in  1  mux output A handshake (io_out_valid & io_out_ready).
- io_d_fire  in  1  D-channel response handshake (d valid & d ready).
- io_d_source  in  SRC_W  source field of the D response.
- io_choseOH  out  NUM_MASTERS  one-hot select to the mux; all-zero means no master selected.
- io_grant_idx  out  SRC_W  binary index of the current or last granted master.
- io_busy  out  1  high in GRANT or WAIT_D.

Behaviour:
- Reset values: state=IDLE, io_choseOH=0, grant_q=0, io_grant_idx=0, io_busy=0, rr_ptr=0.
- States: IDLE, GRANT, WAIT_D; all registered, no combinational path from io_req_valid to io_choseOH.
- IDLE:
  - io_choseOH=0.
  - If any io_req_valid bit is set: winner = pick(io_req_valid, rr_ptr); grant_q<=onehot(winner); state<=GRANT.
  - Grant latency: request seen in cycle N -> io_choseOH asserted in cycle N+1.
- GRANT:
  - io_choseOH=grant_q.
  - On io_a_fire: state<=WAIT_D.
  - Grant is held even if the granted valid drops (protocol violation; no re-arbitration).
  - io_d_fire in this state is ignored.
- WAIT_D:
  - io_choseOH=0, which blocks further A beats because the mux ready is gated by the select.
  - On io_d_fire with io_d_source==grant_idx: state<=IDLE; rr_ptr<=(grant_idx+1) mod NUM_MASTERS.
  - io_d_fire with a non-matching source is ignored.
- Re-arbitration: after returning to IDLE, new requests are arbitrated starting the following cycle. Minimum turnaround A->A is 3 cycles when D returns the cycle after A.
- io_a_fire outside GRANT is ignored.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values; any in-flight response is dropped.
- io_choseOH is one-hot or zero at all times; this is an assertion target.

Optional Feature:
- Macro: TL_BUS_ARB_RR_EN.
- Defined: round-robin. Search starts at rr_ptr and wraps to index 0; rr_ptr advances past the winner on D completion.
- Undefined: fixed priority, lowest index wins. rr_ptr is not instantiated; io_grant_idx is unchanged.

Decomposition:
- Shared package tl_bus_pkg:
  - state enum {IDLE, GRANT, WAIT_D}.
  - TileLink-UL opcode constants: Get=3'h4, PutFullData=3'h0, PutPartialData=3'h1, AccessAck=3'h0, AccessAckData=3'h1.
  - Default size constant 4'h4.
- One sub-module, tl_rr_pick: combinational rotated find-first-set. Inputs: req vector and start pointer. Outputs: one-hot and binary index. The fixed-priority build uses start=0.

Test Plan:
- Reset: hold reset high with io_req_valid=2'b11 -> io_choseOH=0, io_busy=0. Release reset -> io_choseOH=2'b01 one cycle after the first sampling edge.
- Single transaction: req=2'b10 -> cycle+1 io_choseOH=2'b10. Pulse io_a_fire -> io_choseOH=0, io_busy=1. io_d_fire with source=1 -> IDLE, io_busy=0 next cycle.
- Source mismatch: in WAIT_D for master 0, io_d_fire with source=1 -> state stays WAIT_D. Then io_d_fire with source=0 -> IDLE.
- Contention, RR build: req=2'b11 held for 3 transactions -> grants 01, 10, 01. Non-RR build -> grants 01, 01, 01.
- Grant hold: in GRANT for master 1, drop req[1] and raise req[0] -> io_choseOH remains 2'b10 until io_a_fire.
- Async reset in WAIT_D: assert reset between clock edges -> io_choseOH=0 and io_busy=0 immediately; a D response after reset release causes no state change.
